// File: rtl/p6_arb_pkg.sv
// Shared definitions for the p6 ring arbiter.
//   arb_state_e           : arbiter FSM states (IDLE, GRANT, GAP)
//   ARB_N_DEFAULT         : default number of requesters
//   ARB_HOLD_MAX_DEFAULT  : default maximum grant length in cycles
//   ARB_MAX_N             : widest requester vector the rotate helper supports
//   rotl1_onehot()        : rotate an n-bit vector left by one, bit n-1 -> bit 0
package p6_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

  localparam int ARB_N_DEFAULT        = 4;
  localparam int ARB_HOLD_MAX_DEFAULT = 8;
  localparam int ARB_MAX_N            = 32;
  localparam int ARB_IDX_W            = $clog2(ARB_MAX_N);

  // The vector is carried at the maximum width so one function serves every
  // instance; only the low n bits are meaningful and the result is masked to
  // them, with the top live bit wrapping into bit 0.
  function automatic logic [ARB_MAX_N-1:0] rotl1_onehot(
    input logic [ARB_MAX_N-1:0] v,
    input int                   n
  );
    logic [ARB_MAX_N-1:0] mask;
    logic [ARB_MAX_N-1:0] r;
    if (n >= ARB_MAX_N) begin
      mask = '1;
    end else begin
      mask = (ARB_MAX_N'(1) << n) - ARB_MAX_N'(1);
    end
    r    = (v << 1) & mask;
    r[0] = v[ARB_IDX_W'(n - 1)];
    return r;
  endfunction

endpackage : p6_arb_pkg

// File: rtl/p6_ring_pointer.sv
// One-hot rotating priority token for the ring arbiter.
// Holds a single circulating one; when advance_i is high the token is loaded
// with grant_i rotated left by one, so the requester just served drops to the
// lowest priority and its upper neighbour becomes the highest.
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous active-high reset, token returns to bit 0
//   advance_i : load the rotated grant at the next edge
//   grant_i   : one-hot grant being released
//   token_o   : one-hot priority pointer
module p6_ring_pointer
  import p6_arb_pkg::*;
#(
  parameter int N = ARB_N_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         advance_i,
  input  logic [N-1:0] grant_i,
  output logic [N-1:0] token_o
);

  logic [N-1:0] token_q;
  logic [N-1:0] token_d;

  always_comb begin
    token_d = N'(rotl1_onehot(ARB_MAX_N'(grant_i), N));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      token_q <= N'(1);
    end else if (advance_i) begin
      token_q <= token_d;
    end
  end

  assign token_o = token_q;

endmodule : p6_ring_pointer

// File: rtl/p6_ring_arbiter.sv
// Round-robin arbiter sharing one resource among N requesters.
// A one-hot token marks the highest-priority requester; the scan starts at
// the token and wraps upward. Each grant is bounded to HOLD_MAX cycles and
// consecutive grants are always separated by one idle (GAP) cycle.
// Ports:
//   clk         : rising-edge clock
//   reset       : asynchronous active-high reset, clears all state
//   enable      : gates issue of new grants (a running grant is unaffected)
//   req         : request level per requester
//   done        : release pulse, only the granted requester's bit is used
//   grant       : registered one-hot grant
//   grant_valid : registered OR of grant
//   grant_id    : index of the granted requester, 0 when no grant
//   token       : one-hot priority pointer
//   timeout     : one-cycle pulse in the GAP following a forced revoke
module p6_ring_arbiter
  import p6_arb_pkg::*;
#(
  parameter int N        = ARB_N_DEFAULT,
  parameter int HOLD_MAX = ARB_HOLD_MAX_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         done,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_id,
  output logic [N-1:0]         token,
  output logic                 timeout
);

  localparam int ID_W   = $clog2(N);
  localparam int HOLD_W = $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

  arb_state_e        state_q;
  logic [N-1:0]      grant_q;
  logic              grant_valid_q;
  logic [ID_W-1:0]   grant_id_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [HOLD_W-1:0] hold_cnt_d;
  logic              timeout_q;

  logic [N-1:0]      token_w;

  // Priority scan results
  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  logic [N-1:0]      win_onehot;

  // Release decode for the active grant
  logic              owner_done;
  logic              owner_req;
  logic              release_normal;
  logic              release_forced;
  logic              advance;

  // Scan req starting at the token position and wrapping upward; the first
  // set bit wins.
  always_comb begin
    int tok_idx;
    int cand;
    tok_idx    = 0;
    cand       = 0;
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (token_w[i]) begin
        tok_idx = i;
      end
    end
    for (int k = 0; k < N; k++) begin
      cand = (tok_idx + k) % N;
      if (!win_found && req[cand]) begin
        win_found  = 1'b1;
        win_idx    = ID_W'(cand);
        win_onehot = N'(1) << cand;
      end
    end
  end

  // done wins over withdrawal, which wins over the hold limit, so a release
  // that coincides with the last allowed cycle is not reported as a timeout.
  always_comb begin
    owner_done     = done[grant_id_q];
    owner_req      = req[grant_id_q];
    release_normal = (state_q == ST_GRANT) && (owner_done || !owner_req);
    release_forced = (state_q == ST_GRANT) && !(owner_done || !owner_req) &&
                     (hold_cnt_q == HOLD_LAST);
    advance        = release_normal || release_forced;
    hold_cnt_d     = hold_cnt_q + HOLD_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      hold_cnt_q    <= '0;
      timeout_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_GRANT: begin
          if (advance) begin
            state_q       <= ST_GAP;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            hold_cnt_q    <= '0;
            timeout_q     <= release_forced;
          end else begin
            hold_cnt_q    <= hold_cnt_d;
            timeout_q     <= 1'b0;
          end
        end
        // IDLE and GAP arbitrate identically; GAP only exists to force the
        // one-cycle bus-idle after a release.
        default: begin
          timeout_q  <= 1'b0;
          hold_cnt_q <= '0;
          if (enable && win_found) begin
            state_q       <= ST_GRANT;
            grant_q       <= win_onehot;
            grant_valid_q <= 1'b1;
            grant_id_q    <= win_idx;
          end else begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
          end
        end
      endcase
    end
  end

  p6_ring_pointer #(
    .N (N)
  ) u_pointer (
    .clk       (clk),
    .reset     (reset),
    .advance_i (advance),
    .grant_i   (grant_q),
    .token_o   (token_w)
  );

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign token       = token_w;
  assign timeout     = timeout_q;

endmodule : p6_ring_arbiter

// File: tb/tb_p6_ring_arbiter.sv
module tb_p6_ring_arbiter;

  localparam int N  = 4;
  localparam int HM = 8;

  logic       clk    = 1'b0;
  logic       reset  = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] req    = '0;
  logic [3:0] done   = '0;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic [3:0] token;
  logic       timeout;

  p6_ring_arbiter #(
    .N        (N),
    .HOLD_MAX (HM)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .token       (token),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] done;
    logic       en;
    logic [3:0] grant;
    logic [1:0] id;
    logic [3:0] token;
    logic       to;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[18];
  logic [3:0] order[5];
  int checks = 0;
  int errors = 0;

  // reference model state
  logic [3:0] m_tok;
  logic [3:0] m_grant;
  logic [1:0] m_id;
  int         m_hold;
  bit         m_busy;
  bit         m_to;

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] d, input logic e,
                              input logic [3:0] g, input logic [1:0] id,
                              input logic [3:0] tok, input logic to);
    vec_t v;
    v.req = r; v.done = d; v.en = e; v.grant = g; v.id = id; v.token = tok; v.to = to;
    return v;
  endfunction

  function automatic logic [3:0] rotl4(input logic [3:0] g);
    return {g[2:0], g[3]};
  endfunction

  task automatic check_out(input string name, input vec_t e);
    checks++;
    if (grant !== e.grant || grant_valid !== (|e.grant) || grant_id !== e.id ||
        token !== e.token || timeout !== e.to) begin
      errors++;
      $display("FAIL %s @%0t: got grant=%b gv=%b id=%0d token=%b timeout=%b, want grant=%b gv=%b id=%0d token=%b timeout=%b",
               name, $time, grant, grant_valid, grant_id, token, timeout,
               e.grant, |e.grant, e.id, e.token, e.to);
    end
  endtask

  // Drive one cycle of inputs, queue the expected registered result, and
  // compare it once the next rising edge has produced it.
  task automatic apply(input string name, input vec_t v);
    vec_t e;
    req    = v.req;
    done   = v.done;
    enable = v.en;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_out(name, e);
  endtask

  task automatic model_step(input logic [3:0] r, input logic [3:0] d, input logic e);
    int p;
    int j;
    m_to = 1'b0;
    if (m_busy) begin
      if (d[m_id] || !r[m_id] || m_hold == HM - 1) begin
        if (!d[m_id] && r[m_id]) m_to = 1'b1;
        m_busy  = 1'b0;
        m_tok   = rotl4(m_grant);
        m_grant = '0;
        m_id    = '0;
      end else begin
        m_hold++;
      end
    end else if (e && r != 4'b0000) begin
      p = 0;
      for (int i = 0; i < 4; i++) if (m_tok[i]) p = i;
      for (int k = 0; k < 4; k++) begin
        j = (p + k) % 4;
        if (!m_busy && r[j]) begin
          m_busy  = 1'b1;
          m_id    = 2'(j);
          m_grant = 4'b0001 << j;
          m_hold  = 0;
        end
      end
    end
  endtask

  initial begin
    logic [3:0] rr;
    logic [3:0] rd;
    logic       re;
    logic [3:0] g;

    // Single requester, token wrap, withdrawal, enable gating
    tbl[0]  = mk(4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd2, 4'b0001, 1'b0);
    tbl[1]  = mk(4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd2, 4'b0001, 1'b0);
    tbl[2]  = mk(4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd2, 4'b0001, 1'b0);
    tbl[3]  = mk(4'b0100, 4'b0100, 1'b1, 4'b0000, 2'd0, 4'b1000, 1'b0);
    tbl[4]  = mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 4'b1000, 1'b0);
    tbl[5]  = mk(4'b0011, 4'b0000, 1'b1, 4'b0001, 2'd0, 4'b1000, 1'b0);
    tbl[6]  = mk(4'b0011, 4'b0001, 1'b1, 4'b0000, 2'd0, 4'b0010, 1'b0);
    tbl[7]  = mk(4'b0011, 4'b0000, 1'b1, 4'b0010, 2'd1, 4'b0010, 1'b0);
    tbl[8]  = mk(4'b0001, 4'b0000, 1'b1, 4'b0000, 2'd0, 4'b0100, 1'b0);
    tbl[9]  = mk(4'b1111, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0100, 1'b0);
    tbl[10] = mk(4'b1111, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b0100, 1'b0);
    tbl[11] = mk(4'b1111, 4'b0000, 1'b1, 4'b0100, 2'd2, 4'b0100, 1'b0);
    tbl[12] = mk(4'b1111, 4'b1011, 1'b0, 4'b0100, 2'd2, 4'b0100, 1'b0);
    tbl[13] = mk(4'b1111, 4'b0100, 1'b0, 4'b0000, 2'd0, 4'b1000, 1'b0);
    tbl[14] = mk(4'b1111, 4'b0000, 1'b0, 4'b0000, 2'd0, 4'b1000, 1'b0);
    tbl[15] = mk(4'b1111, 4'b0000, 1'b1, 4'b1000, 2'd3, 4'b1000, 1'b0);
    tbl[16] = mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 4'b0001, 1'b0);
    tbl[17] = mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 4'b0001, 1'b0);

    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;

    // Reset takes effect without a clock edge
    #1 reset = 1'b1;
    #2;
    check_out("reset_state", mk(4'b0, 4'b0, 1'b0, 4'b0000, 2'd0, 4'b0001, 1'b0));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 18; i++) begin
      apply($sformatf("vec%0d", i), tbl[i]);
    end

    // All requesting: rotation order with one idle cycle between grants
    for (int k = 0; k < 5; k++) begin
      g = order[k];
      apply($sformatf("rr_grant%0d", k),   mk(4'b1111, 4'b0000, 1'b1, g, 2'(k % 4), g, 1'b0));
      apply($sformatf("rr_hold%0d", k),    mk(4'b1111, 4'b0000, 1'b1, g, 2'(k % 4), g, 1'b0));
      apply($sformatf("rr_release%0d", k), mk(4'b1111, g, 1'b1, 4'b0000, 2'd0, rotl4(g), 1'b0));
    end
    apply("rr_idle", mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 4'b0010, 1'b0));

    // Hold limit: exactly HM grant cycles, timeout in the GAP, then reissue
    for (int i = 0; i < HM; i++) begin
      apply($sformatf("hold_grant%0d", i), mk(4'b0001, 4'b0000, 1'b1, 4'b0001, 2'd0, 4'b0010, 1'b0));
    end
    apply("hold_timeout", mk(4'b0001, 4'b0000, 1'b1, 4'b0000, 2'd0, 4'b0010, 1'b1));
    apply("hold_regrant", mk(4'b0001, 4'b0000, 1'b1, 4'b0001, 2'd0, 4'b0010, 1'b0));
    for (int i = 1; i < HM; i++) begin
      apply($sformatf("hold2_grant%0d", i), mk(4'b0001, 4'b0000, 1'b1, 4'b0001, 2'd0, 4'b0010, 1'b0));
    end
    // done on the last allowed cycle is a normal release
    apply("hold_done_at_limit", mk(4'b0001, 4'b0001, 1'b1, 4'b0000, 2'd0, 4'b0010, 1'b0));
    apply("hold_idle", mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 4'b0010, 1'b0));

    // Reset mid-grant
    apply("rst_pre", mk(4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd2, 4'b0010, 1'b0));
    #2 reset = 1'b1;
    #1;
    check_out("rst_async", mk(4'b0100, 4'b0000, 1'b1, 4'b0000, 2'd0, 4'b0001, 1'b0));
    @(posedge clk);
    #1;
    check_out("rst_held", mk(4'b0100, 4'b0000, 1'b1, 4'b0000, 2'd0, 4'b0001, 1'b0));
    @(negedge clk);
    reset = 1'b0;
    apply("rst_resume", mk(4'b0100, 4'b0000, 1'b1, 4'b0100, 2'd2, 4'b0001, 1'b0));
    apply("rst_release", mk(4'b0000, 4'b0000, 1'b1, 4'b0000, 2'd0, 4'b1000, 1'b0));

    // Random traffic against the reference model, from a fresh reset
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    m_tok   = 4'b0001;
    m_grant = '0;
    m_id    = '0;
    m_hold  = 0;
    m_busy  = 1'b0;
    m_to    = 1'b0;
    rr      = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) rr = rr ^ 4'($urandom);
      rd = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      re = ($urandom_range(0, 9) != 0);
      model_step(rr, rd, re);
      apply("random", mk(rr, rd, re, m_grant, m_id, m_tok, m_to));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_p6_ring_arbiter
